// File: rtl/d_ff_serial_receiver.sv
// d_ff_serial_receiver: synchronizes an asynchronous serial line, mirrors it as q/qbar,
// deframes start/data/stop frames into words and counts line transitions.
module d_ff_serial_receiver #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             d,
   input  logic             en,
   output logic             q,
   output logic             qbar,
   output logic [WIDTH-1:0] word,
   output logic             word_valid,
   output logic             frame_err,
   output logic             busy,
   output logic [7:0]       toggle_count
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   typedef enum logic [1:0] {IDLE, SHIFT, STOP} state_t;
   state_t state, state_n;
   logic s1, q_d;
   logic [CW-1:0] bit_cnt, bit_cnt_n;
   logic [WIDTH-1:0] shreg, shreg_n, word_n;
   logic word_valid_n, frame_err_n;
   assign qbar = ~q;
   assign busy = state != IDLE;
   always_ff @(posedge clk) begin
      if (rst) begin
         s1           <= 1'b0;
         q            <= 1'b0;
         q_d          <= 1'b0;
         toggle_count <= 8'd0;
         state        <= IDLE;
         bit_cnt      <= '0;
         shreg        <= '0;
         word         <= '0;
         word_valid   <= 1'b0;
         frame_err    <= 1'b0;
      end else begin
         s1           <= d;
         q            <= s1;
         q_d          <= q;
         toggle_count <= (q != q_d && toggle_count != 8'hff) ? toggle_count + 8'd1 : toggle_count;
         state        <= state_n;
         bit_cnt      <= bit_cnt_n;
         shreg        <= shreg_n;
         word         <= word_n;
         word_valid   <= word_valid_n;
         frame_err    <= frame_err_n;
      end
   end
   // a stop sample always returns to IDLE, so a stop bit of 1 never doubles as a start bit
   always_comb begin
      state_n      = state;
      bit_cnt_n    = bit_cnt;
      shreg_n      = shreg;
      word_n       = word;
      word_valid_n = 1'b0;
      frame_err_n  = 1'b0;
      if (en)
         case (state)
            IDLE: begin
               state_n   = q ? SHIFT : IDLE;
               bit_cnt_n = q ? '0 : bit_cnt;
            end
            SHIFT: begin
               shreg_n[bit_cnt] = q;
               bit_cnt_n        = bit_cnt + 1'b1;
               state_n          = (bit_cnt == LAST) ? STOP : SHIFT;
            end
            STOP: begin
               state_n      = IDLE;
               word_n       = q ? word : shreg;
               word_valid_n = ~q;
               frame_err_n  = q;
            end
            default: state_n = IDLE;
         endcase
   end
endmodule

// File: tb/tb_d_ff_serial_receiver.sv
// tb_d_ff_serial_receiver: directed and random stimulus checked against a frame-position reference model.
module tb_d_ff_serial_receiver;
   localparam int W = 8;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic d = 1'b0;
   logic en = 1'b1;
   logic q, qbar, word_valid, frame_err, busy;
   logic [W-1:0] word;
   logic [7:0] toggle_count;
   int total = 0;
   int bad = 0;
   int cyc = 0;
   logic e1 = 1'b1;
   logic e2 = 1'b1;
   logic m_s1 = 1'b0, m_q = 1'b0, m_qd = 1'b0, m_wv = 1'b0, m_fe = 1'b0;
   logic [W-1:0] m_sh = '0, m_word = '0;
   int m_tc = 0;
   int fp = 0;
   int wv_n = 0, fe_n = 0, last_wv = 0, prev_wv = 0;
   logic [W-1:0] wv_words[$];
   int c0, wv0, fe0;

   d_ff_serial_receiver #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .d(d), .en(en), .q(q), .qbar(qbar), .word(word),
      .word_valid(word_valid), .frame_err(frame_err), .busy(busy), .toggle_count(toggle_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // fp: 0 hunting for a start bit, 1..W next data bit index+1, W+1 expecting the stop bit
   task automatic model(input logic dv, input logic ev, input logic rv);
      if (rv) begin
         m_s1 = 0; m_q = 0; m_qd = 0; m_tc = 0; fp = 0; m_sh = '0; m_word = '0; m_wv = 0; m_fe = 0;
      end else begin
         m_wv = 0;
         m_fe = 0;
         if (m_q != m_qd && m_tc < 255) m_tc++;
         if (ev) begin
            if (fp == 0) begin
               if (m_q) fp = 1;
            end else if (fp <= W) begin
               m_sh[fp-1] = m_q;
               fp++;
            end else begin
               if (m_q) m_fe = 1;
               else begin
                  m_word = m_sh;
                  m_wv = 1;
               end
               fp = 0;
            end
         end
         m_qd = m_q;
         m_q  = m_s1;
         m_s1 = dv;
      end
   endtask

   // er is the enable that belongs to the bit being driven; it reaches en two edges later,
   // when that bit is on q
   task automatic step(input logic dv, input logic er, input logic rv = 1'b0);
      d   = dv;
      en  = e2;
      rst = rv;
      e2  = e1;
      e1  = er;
      model(d, en, rst);
      @(posedge clk);
      #1;
      cyc++;
      chk("q", {15'd0, q}, {15'd0, m_q});
      chk("qbar", {15'd0, qbar}, {15'd0, ~m_q});
      chk("word", {8'd0, word}, {8'd0, m_word});
      chk("word_valid", {15'd0, word_valid}, {15'd0, m_wv});
      chk("frame_err", {15'd0, frame_err}, {15'd0, m_fe});
      chk("busy", {15'd0, busy}, {15'd0, fp != 0});
      chk("toggle_count", {8'd0, toggle_count}, 16'(m_tc));
      if (word_valid === 1'b1) begin
         wv_n++;
         prev_wv = last_wv;
         last_wv = cyc;
         wv_words.push_back(word);
      end
      if (frame_err === 1'b1) fe_n++;
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b1);
   endtask

   task automatic frame(input logic [W-1:0] w, input logic stop, input int gap_at = -1);
      step(1'b1, 1'b1);
      for (int i = 0; i < W; i++) begin
         step(w[i], 1'b1);
         if (i == gap_at) repeat (3) step(w[i], 1'b0);
      end
      step(stop, 1'b1);
   endtask

   initial begin
      step(1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b1);
      chk("rst_q", {15'd0, q}, 16'd0);
      chk("rst_qbar", {15'd0, qbar}, 16'd1);
      chk("rst_word", {8'd0, word}, 16'd0);
      chk("rst_busy", {15'd0, busy}, 16'd0);
      chk("rst_toggle", {8'd0, toggle_count}, 16'd0);
      step(1'b1, 1'b1);
      chk("rel1_q", {15'd0, q}, 16'd0);
      step(1'b1, 1'b1);
      chk("rel2_q", {15'd0, q}, 16'd1);
      step(1'b0, 1'b1);
      chk("rel3_toggle", {8'd0, toggle_count}, 16'd1);
      idle(16);
      c0 = cyc + 1;
      wv0 = wv_n;
      fe0 = fe_n;
      frame(8'hA5, 1'b0);
      idle(2);
      chk("a5_word", {8'd0, word}, 16'h00A5);
      chk("a5_latency", 16'(last_wv - c0), 16'd11);
      chk("a5_pulses", 16'(wv_n - wv0), 16'd1);
      chk("a5_no_err", 16'(fe_n - fe0), 16'd0);
      wv0 = wv_n;
      frame(8'hA5, 1'b1);
      idle(2);
      chk("ferr_word_kept", {8'd0, word}, 16'h00A5);
      chk("ferr_pulse", 16'(fe_n - fe0), 16'd1);
      chk("ferr_no_valid", 16'(wv_n - wv0), 16'd0);
      chk("ferr_idle", {15'd0, busy}, 16'd0);
      idle(3);
      c0 = cyc + 1;
      frame(8'h3C, 1'b0, 3);
      idle(2);
      chk("gap_word", {8'd0, word}, 16'h003C);
      chk("gap_latency", 16'(last_wv - c0), 16'd14);
      idle(3);
      wv0 = wv_n;
      fe0 = fe_n;
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1);
      chk("abort_busy", {15'd0, busy}, 16'd0);
      idle(4);
      chk("abort_no_valid", 16'(wv_n - wv0), 16'd0);
      chk("abort_no_err", 16'(fe_n - fe0), 16'd0);
      frame(8'h01, 1'b0);
      frame(8'hFF, 1'b0);
      idle(2);
      chk("b2b_pulses", 16'(wv_n - wv0), 16'd2);
      chk("b2b_spacing", 16'(last_wv - prev_wv), 16'd10);
      if (wv_words.size() >= 2) begin
         chk("b2b_first", {8'd0, wv_words[wv_words.size()-2]}, 16'h0001);
         chk("b2b_second", {8'd0, wv_words[wv_words.size()-1]}, 16'h00FF);
      end else chk("b2b_words", 16'(wv_words.size()), 16'd2);
      for (int i = 0; i < 300; i++) step(i[0], 1'b1);
      idle(3);
      chk("toggle_sat", {8'd0, toggle_count}, 16'd255);
      for (int i = 0; i < 800; i++)
         step(1'($urandom), $urandom_range(0, 7) != 0, $urandom_range(0, 99) == 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/d_ff_serial_receiver.md
# d_ff_serial_receiver

Receiving end for the single-bit serial stream our flip-flop benches drive: it synchronizes an asynchronously changing `d` line, mirrors it as a registered `q`/`qbar` pair, and deframes start-bit / data / stop-bit frames into parallel words. It also counts line transitions. It sits between a home-automation sensor or control line and the word-level control logic.

## Interface
- `WIDTH`, 8, data bits per frame (2..16)
- `clk`  in  1  single system clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `d`  in  1  serial line, asynchronous to `clk`
- `en`  in  1  sample enable; FSM and shift logic advance only when 1
- `q`  out  1  synchronized line value (second sync stage)
- `qbar`  out  1  always `~q`
- `word`  out  WIDTH  last good received word, LSB = first data bit
- `word_valid`  out  1  one-cycle pulse when `word` updates
- `frame_err`  out  1  one-cycle pulse on bad stop bit
- `busy`  out  1  high in SHIFT and STOP states
- `toggle_count`  out  8  count of `q` transitions, saturating

## Operation
- Sync chain: `s1 <= d`, `q <= s1`, `q_d <= q`. Runs every cycle, regardless of `en`.
- The FSM has three states: IDLE, SHIFT, STOP. All transitions require `en=1`; with `en=0` the state, bit counter and shift register hold.
- IDLE: if `q=1` (start bit) -> SHIFT, and `bit_cnt <= 0`.
- SHIFT: shift register bit `bit_cnt` is loaded from `q`, then `bit_cnt++`.
  - When `bit_cnt == WIDTH-1` on this sample -> STOP.
- STOP: sample `q` as the stop bit.
  - `q=0`: `word <= shreg`, `word_valid <= 1`.
  - `q=1`: `frame_err <= 1`, `word` unchanged.
  - Either way -> IDLE.
  - A stop bit of 1 does not count as a new start bit; a new frame needs a fresh IDLE sample of 1.
- `word_valid` and `frame_err` default to 0 every cycle; they are never both high.
- `toggle_count`:
  - Increments when `q != q_d`; saturates at 255.
  - Cleared only by `rst`.
  - Unaffected by `en`.
- `bit_cnt` width is `$clog2(WIDTH)`; no wrap-around is possible because the count exits at `WIDTH-1`.

## Timing
- Reset (synchronous, `rst=1` at an edge): `s1=q=q_d=0`, `qbar=1`, `word=0`, `word_valid=0`, `frame_err=0`, `busy=0`, `toggle_count=0`, state IDLE, `bit_cnt=0`, shift register 0.
- Reset asserted mid-frame aborts the frame: no `word_valid` and no `frame_err`.
- Input latency: `d` stable across edge k appears on `q` after edge k+1.
- `qbar` is combinational from `q`.
- Frame timing with `en=1` continuously, start bit seen on `q` in IDLE at edge t:
  - Data bits are sampled at edges t+1 .. t+WIDTH.
  - The stop bit is sampled at edge t+WIDTH+1.
  - `word_valid` / `frame_err` are high for the one cycle following edge t+WIDTH+1.
  - `busy` is high from edge t until edge t+WIDTH+1.
- Minimum frame spacing: the next start bit is accepted at edge t+WIDTH+2, giving back-to-back frames.
- `en` gaps stretch the frame by the number of `en=0` cycles; sampled bits are unchanged.

## Test plan
- Reset: drive `d=1`, `rst=1` for 2 cycles -> all outputs at reset values, `qbar=1`; release `rst` -> `q=1` two edges after release, `toggle_count=1`.
- Good frame, WIDTH=8, `en=1`: `d` = 1, then 0xA5 LSB-first (1,0,1,0,0,1,0,1), then 0, one bit per clock -> `word=0xA5`, `word_valid` high exactly 1 cycle, 10 edges after the start bit reaches `q`; `frame_err=0`.
- Framing error: same frame as above with stop bit 1 -> `frame_err` 1-cycle pulse, `word` keeps the previous value 0xA5, `word_valid` stays 0, FSM returns to IDLE.
- Enable gaps: send 0x3C with `en` low for 3 cycles mid-frame while `d` holds the current bit -> `word=0x3C`, `word_valid` delayed 3 cycles vs. the no-gap case.
- Reset mid-frame plus back-to-back frames: assert `rst` after 4 data bits -> no pulses, `busy=0`; then send 0x01 and 0xFF with no idle between -> two `word_valid` pulses 10 cycles apart, `word` = 0x01 then 0xFF.
- Toggle saturation: toggle `d` every cycle for 300 cycles -> `toggle_count` reaches 255 and holds; `q` tracks `d` with 2-cycle latency throughout.
